// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: holds every domain in reset for HOLD_CYCLES, then
// releases the domains one at a time in index order, GAP_CYCLES apart.
// Each clock enable follows its reset release by one cycle. A request input
// aborts whatever is in progress and re-runs the whole sequence.
module reset_release_sequencer #(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req,
    output logic [N_STAGES-1:0] o_rst,
    output logic [N_STAGES-1:0] o_rst_n,
    output logic [N_STAGES-1:0] o_clk_en,
    output logic                o_busy,
    output logic                o_done
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_WIDTH  = $clog2(MAX_CYCLES + 1);
    localparam int IDX_WIDTH  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(N_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [IDX_WIDTH-1:0]  idx_inc;
    logic [N_STAGES-1:0]   rst_d;
    logic [N_STAGES-1:0]   clk_en_d;
    logic                  busy_d;
    logic                  done_d;

    assign idx_inc = idx_q + 1'b1;

    // Next-state and next-output logic; a request overrides every state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rst_d    = o_rst;
        // Enables trail the reset release by one edge.
        clk_en_d = ~o_rst;
        busy_d   = o_busy;
        done_d   = 1'b0;

        if (i_req) begin
            state_d  = HOLD;
            cnt_d    = '0;
            idx_d    = '0;
            rst_d    = '1;
            clk_en_d = '0;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_d[0] = 1'b0;
                        cnt_d    = '0;
                        idx_d    = '0;
                        state_d  = RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_inc;
                            for (int k = 0; k < N_STAGES; k++) begin
                                if (k == int'(idx_inc)) rst_d[k] = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    rst_d  = '0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset restarts the full sequence.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            o_rst    <= '1;
            o_rst_n  <= '0;
            o_clk_en <= '0;
            o_busy   <= 1'b1;
            o_done   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            o_rst    <= rst_d;
            o_rst_n  <= ~rst_d;
            o_clk_en <= clk_en_d;
            o_busy   <= busy_d;
            o_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: a default instance and a minimal
// (1 stage, 1 hold, 1 gap) instance share rst/req. Expected outputs come from
// a schedule model indexed by the number of clean edges since the last
// reset or request.
module tb_reset_release_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic req = 1'b0;

    logic [2:0] rst0, rstn0, ce0;
    logic       busy0, done0;
    logic [0:0] rst1, rstn1, ce1;
    logic       busy1, done1;

    reset_release_sequencer #(.N_STAGES(3), .HOLD_CYCLES(16), .GAP_CYCLES(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_rst(rst0), .o_rst_n(rstn0), .o_clk_en(ce0), .o_busy(busy0), .o_done(done0)
    );

    reset_release_sequencer #(.N_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_rst(rst1), .o_rst_n(rstn1), .o_clk_en(ce1), .o_busy(busy1), .o_done(done1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0     = -1;   // last clean edge number for dut0, -1 = in reset/request
    int e1     = -1;

    logic [63:0] obs;
    logic [63:0] exp_v;

    assign obs = {8'(rst0), 8'(rstn0), 8'(ce0), 6'd0, busy0, done0,
                  8'(rst1), 8'(rstn1), 8'(ce1), 6'd0, busy1, done1};

    // Outputs expected after clean edge e of a sequence with n/h/g settings.
    function automatic logic [31:0] model(int e, int n, int h, int g);
        logic [7:0] r, c, m;
        logic b, d;
        m = 8'((1 << n) - 1);
        r = '0;
        c = '0;
        if (e < 0) begin
            r = m;
            b = 1'b1;
            d = 1'b0;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (e < h - 1 + k * g) r[k] = 1'b1;
                if (e >= h + k * g)    c[k] = 1'b1;
            end
            b = (e < h - 1 + n * g);
            d = (e == h - 1 + n * g);
        end
        return {r, ~r & m, c, 6'd0, b, d};
    endfunction

    task automatic tick(input bit r, input bit q);
        rst = r;
        req = q;
        @(posedge clk);
        if (r || q) begin
            e0 = -1;
            e1 = -1;
        end else begin
            if (e0 < 100000) e0++;
            if (e1 < 100000) e1++;
        end
        exp_v = {model(e0, 3, 16, 4), model(e1, 1, 1, 1)};
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL power_on_seq cyc=%0d e=%0d got=%h exp=%h", cyc, e0, obs, exp_v);
            end
        end
    endtask

    task automatic test_req_idle();
        tick(1'b0, 1'b1);
        checks++;
        if (rst0 !== 3'b111 || ce0 !== 3'b000 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL req_idle_restart got rst=%b ce=%b busy=%b exp rst=111 ce=000 busy=1",
                     rst0, ce0, busy0);
        end
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL req_idle cyc=%0d e=%0d got=%h exp=%h", cyc, e0, obs, exp_v);
            end
        end
    endtask

    task automatic test_req_held();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL req_held_on cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL req_held_off cyc=%0d e=%0d got=%h exp=%h", cyc, e0, obs, exp_v);
            end
        end
    endtask

    task automatic test_req_mid_release();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 21; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        checks++;
        if (rst0 !== 3'b111 || ce0 !== 3'b000 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL req_abort got rst=%b ce=%b done=%b exp rst=111 ce=000 done=0",
                     rst0, ce0, done0);
        end
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL req_abort_rerun cyc=%0d e=%0d got=%h exp=%h", cyc, e0, obs, exp_v);
            end
        end
    endtask

    task automatic test_rst_mid_release();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 24; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
        end
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_rerun cyc=%0d e=%0d got=%h exp=%h", cyc, e0, obs, exp_v);
            end
        end
    endtask

    task automatic test_req_at_done();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 27; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || rst0 !== 3'b111) begin
            errors++;
            $display("FAIL req_at_done got done=%b busy=%b rst=%b exp done=0 busy=1 rst=111",
                     done0, busy0, rst0);
        end
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL req_at_done_rerun cyc=%0d e=%0d got=%h exp=%h", cyc, e0, obs, exp_v);
            end
        end
    endtask

    task automatic test_small();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (rst1 !== 1'b0 || rstn1 !== 1'b1 || ce1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL small_e0 got rst=%b rstn=%b ce=%b done=%b exp 0 1 0 0",
                     rst1, rstn1, ce1, done1);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (ce1 !== 1'b1 || done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL small_e1 got ce=%b done=%b busy=%b exp 1 1 0", ce1, done1, busy1);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (done1 !== 1'b0 || ce1 !== 1'b1) begin
            errors++;
            $display("FAIL small_e2 got done=%b ce=%b exp 0 1", done1, ce1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            tick(($urandom % 60) == 0, ($urandom % 30) == 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d e0=%0d e1=%0d got=%h exp=%h", cyc, e0, e1, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_req_idle();
        test_req_held();
        test_req_mid_release();
        test_rst_mid_release();
        test_req_at_done();
        test_small();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_release_sequencer.md
Name: reset_release_sequencer

Overview:
- Generates the per-domain reset and clock-enable signals consumed by downstream logic that casts plain logic to reset/clock types.
- Provides both polarities: active-high `o_rst` and active-low `o_rst_n`.
- Holds all domains in reset for a programmable stretch, then releases them one at a time in index order, with a fixed gap between stages.
- A software reset request re-runs the full sequence.

Parameters:
- N_STAGES, 3, number of reset domains released in order (>=1).
- HOLD_CYCLES, 16, cycles all resets stay asserted before stage 0 releases (>=1).
- GAP_CYCLES, 4, cycles between consecutive stage releases, and between the last release and o_done (>=1).
- CNT_WIDTH, $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1), counter width (derived, not overridden).

Ports:
- i_clk, input, 1: sole clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_req, input, 1: sequence request, sampled every cycle.
- o_rst, output, N_STAGES: per-domain reset, active-high.
- o_rst_n, output, N_STAGES: per-domain reset, active-low; always the bitwise complement of o_rst.
- o_clk_en, output, N_STAGES: per-domain clock enable.
- o_busy, output, 1: high while a sequence is in progress.
- o_done, output, 1: single-cycle pulse when the sequence completes.

Behaviour:
- One clock, i_clk. Reset i_rst is synchronous and active-high. All outputs are registered.
- Reset values (while i_rst=1):
  - o_rst all 1, o_rst_n all 0, o_clk_en all 0.
  - o_busy=1, o_done=0.
  - state=HOLD, cnt=0, idx=0.
  - A full sequence therefore runs automatically after reset.
- FSM states: IDLE, HOLD, RELEASE.
- HOLD:
  - cnt increments each edge.
  - At an edge where cnt==HOLD_CYCLES-1: o_rst[0]<=0, cnt<=0, idx<=0, state<=RELEASE.
- RELEASE:
  - cnt increments each edge.
  - At cnt==GAP_CYCLES-1 with idx<N_STAGES-1: idx<=idx+1, o_rst[idx+1]<=0, cnt<=0.
  - At cnt==GAP_CYCLES-1 with idx==N_STAGES-1: o_done<=1 for exactly one cycle, o_busy<=0, state<=IDLE.
- IDLE: all o_rst=0, all o_clk_en=1, o_busy=0; holds until i_req.
- Clock enable: o_clk_en[k] rises one edge after o_rst[k] falls. o_clk_en[k] falls on the same edge that o_rst[k] rises.
- Release schedule, with edges e0,e1,... counted from the first edge where i_rst=0:
  - stage k releases at edge e(HOLD_CYCLES-1+k*GAP_CYCLES).
  - o_done is visible after edge e(HOLD_CYCLES-1+N_STAGES*GAP_CYCLES).
- i_req=1 in any state, including IDLE:
  - next edge: all o_rst<=1, all o_clk_en<=0, o_busy<=1, o_done<=0, cnt<=0, idx<=0, state<=HOLD.
  - Held i_req keeps restarting HOLD; the hold count begins on the first edge with i_req=0.
- i_req on the same edge as a final-stage completion: the request wins. o_done is not pulsed and the FSM returns to HOLD.
- i_rst has priority over i_req.
- Monotonic release: no o_rst bit deasserts before any lower-index bit.
- No o_rst bit reasserts except by i_rst or i_req.
- Counter compare uses CNT_WIDTH-bit unsigned arithmetic; cnt never wraps.

Test Plan:
- Defaults; i_rst high for 3 cycles, then low -> o_rst[0] low after e15, o_rst[1] after e19, o_rst[2] after e23; o_clk_en[k] each one edge later; o_done high for exactly the cycle after e27; o_busy low from e27; o_rst_n==~o_rst on every cycle.
- From IDLE, pulse i_req for 1 cycle at edge eR -> all o_rst=1 and o_clk_en=0 after eR; o_rst[0] releases after eR+16; done after eR+28.
- Hold i_req high for 10 cycles during HOLD -> hold count restarts; o_rst[0] releases 16 edges after the last edge with i_req=1.
- i_req asserted after stage 1 released (cycle e21) -> o_rst returns to 3'b111 and o_clk_en to 0 next edge; full sequence reruns; no o_done pulse from the aborted run.
- i_rst asserted mid-RELEASE -> outputs reach their reset values on the next edge; after i_rst low, the release schedule starts from e0 again.
- N_STAGES=1, HOLD_CYCLES=1, GAP_CYCLES=1 -> o_rst[0] low after e0, o_clk_en[0] high after e1, o_done pulses after e1.
